gpio_apb: RTL and testbench
===========================

# gpio_apb

8-bit general-purpose I/O peripheral with an APB-style slave port. It sits on the APB bus as slave 0 of a two-slave select vector (the UART is slave 1). Software programs per-pin direction and output value and reads back pin state through it. Each pin drives its port bit when configured as an output and is released (high-Z) when configured as an input.

## Interface
- No parameters; pin count fixed at 8, register map fixed.
- PCLK  in  1  bus clock; all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  32  byte-agnostic register index (0..3 valid).
- PWDATA  in  32  write data; only bits [7:0] are used.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  2  slave select; bit 0 selects this block, bit 1 is ignored.
- PPROT  in  3  protection attributes; accepted and ignored.
- PRDATA  out  32  read data, zero-extended from 8 bits.
- PREADY  out  1  transfer completes in the cycle it is high.
- PSLVERR  out  1  error flag, valid only while PREADY=1.
- PINS  inout  8  GPIO pads.

## Operation
- Register map: 0 = PIN (RO, sampled pad values); 1 = reserved; 2 = DIR (RW, 1 = output, 0 = input); 3 = PORT (RW, output value).
- Pad drive: PINS[i] = DIR[i] ? PORT[i] : Z, continuously from the registers.
- The block has no PENABLE input. An internal FSM (IDLE, SETUP, ACCESS) generates the two APB phases from PSEL[0]:
  - IDLE -> SETUP when PSEL[0]=1.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> SETUP if PSEL[0]=1 (back-to-back transfers), otherwise ACCESS -> IDLE.
- The write commits at the rising edge that ends ACCESS, when PWRITE=1 and the address is 2 or 3. PWDATA[7:0] is loaded into DIR or PORT.
- Reads: PRDATA is registered at the SETUP->ACCESS edge and holds until the next read capture. Address 0 returns the sampled PINS value, 2 returns DIR, 3 returns PORT, and 1 returns 0.
- Errors: PSLVERR=1 during ACCESS for PADDR > 3, or for a write to address 0 or 1. An errored write changes no register. An errored read returns PRDATA=0.
- Simultaneous events: a write to DIR or PORT becomes visible on PINS in the cycle after the commit edge. A read of PIN in the same transfer sees the pre-write value.
- Input pads in high-Z read as the externally driven value. Output pads read back their own driven value.
- PSEL[0] dropping during SETUP: the FSM still completes ACCESS. Bus masters must hold the address and control signals stable for the full transfer.

## Timing
- Reset values (asynchronous, immediate): FSM=IDLE, DIR=0x00 (all pins high-Z), PORT=0x00, PRDATA=0, PREADY=0, PSLVERR=0.
- Reset asserted mid-transfer aborts it; no register is written.
- PREADY is 1 exactly while in ACCESS, giving zero wait states. Each transfer takes 2 cycles; continuous PSEL gives a transfer every 2 cycles.
- Write latency: PINS reflect new DIR/PORT 1 cycle after the ACCESS commit edge, which is at most 3 cycles after PSEL[0] rises from IDLE.
- PIN sampling latency: 1 cycle (one register) without synchronizer, 2 cycles with synchronizer (see Configuration).

## Configuration
- GPIO_IN_SYNC_EN defined: PIN reads come from a 2-flop synchronizer on PINS. Both flops reset to 0.
- Not defined: PIN reads come from a single sampling register, reset to 0.
- Register map, pad behaviour and bus timing are otherwise identical in both builds.

## Test plan
- Reset: hold PRESETn=0 for 2 cycles -> PINS all Z, PRDATA=0, PREADY=0, PSLVERR=0.
- Continuous write DIR: PSEL=01, PWRITE=1, PADDR=2, PWDATA=15 for 6 cycles -> PINS = ZZZZ_0000, PREADY toggles every cycle, PSLVERR=0.
- Write PORT: PADDR=3, PWDATA=7 with DIR=0x0F -> PINS low nibble = 0111, upper nibble Z.
- Read DIR: PWRITE=0, PADDR=2 -> PRDATA=0x0000000F while PREADY=1.
- Read PIN: external drive of upper nibble = 1010, DIR=0x0F, PORT=0x07 -> PRDATA=0x000000A7 after the configured sync latency.
- Errors: write PADDR=5 or PADDR=0 -> PSLVERR=1 in ACCESS, DIR/PORT unchanged. PSEL=10 -> FSM stays IDLE, PREADY=0.

Source files
------------

// File: rtl/gpio_apb_if.sv
// APB-style bus bundle for gpio_apb: address/data/control from the master,
// read data and completion/error flags back from the slave.
`timescale 1ns/1ps
interface gpio_apb_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [1:0]  PSEL;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/gpio_apb.sv
// 8-bit GPIO with APB-style slave (bus slave 0); internal FSM derives SETUP/ACCESS from PSEL[0].
// Define GPIO_IN_SYNC_EN to sample the pads through a 2-flop synchronizer.
`timescale 1ns/1ps
module gpio_apb (
  input  logic       PCLK,
  input  logic       PRESETn,
  gpio_apb_if.slave  apb,
  inout  wire  [7:0] PINS
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dir_q, port_q;
  logic [7:0]  pin_smp;
  logic [31:0] prdata_q, prdata_d;
  logic        addr_bad, err;
  logic        unused_ok;

  assign unused_ok = ^{apb.PPROT, apb.PWDATA[31:8], apb.PSEL[1]};

  // Writes are only legal to DIR (2) and PORT (3); anything above 3 errors.
  assign addr_bad = (apb.PADDR > 32'd3);
  assign err      = addr_bad | (apb.PWRITE & ~apb.PADDR[1]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (apb.PSEL[0]) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = apb.PSEL[0] ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      dir_q  <= '0;
      port_q <= '0;
    end else if (state_q == ACCESS && apb.PWRITE && !err) begin
      if (apb.PADDR[0]) port_q <= apb.PWDATA[7:0];
      else              dir_q  <= apb.PWDATA[7:0];
    end
  end

  always_comb begin
    prdata_d = '0;
    if (!addr_bad) begin
      unique case (apb.PADDR[1:0])
        2'd0:    prdata_d = {24'd0, pin_smp};
        2'd2:    prdata_d = {24'd0, dir_q};
        2'd3:    prdata_d = {24'd0, port_q};
        default: prdata_d = '0;
      endcase
    end
  end

  // Read data is captured entering ACCESS and held until the next read.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                             prdata_q <= '0;
    else if (state_q == SETUP && !apb.PWRITE) prdata_q <= prdata_d;
  end

`ifdef GPIO_IN_SYNC_EN
  logic [7:0] sync1_q, sync2_q;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= PINS;
      sync2_q <= sync1_q;
    end
  end
  assign pin_smp = sync2_q;
`else
  logic [7:0] samp_q;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) samp_q <= '0;
    else          samp_q <= PINS;
  end
  assign pin_smp = samp_q;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_pad
    assign PINS[i] = dir_q[i] ? port_q[i] : 1'bz;
  end

  assign apb.PREADY  = (state_q == ACCESS);
  assign apb.PSLVERR = (state_q == ACCESS) && err;
  assign apb.PRDATA  = prdata_q;
endmodule

// File: tb/tb_gpio_apb.sv
// Self-checking bench for gpio_apb: directed scenarios plus randomized transfers
// checked against a register-level model of DIR/PORT and the external pad drive.
`timescale 1ns/1ps
module tb_gpio_apb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ext_oe, ext_val;
  logic [7:0] m_dir, m_port;
  int         n_chk = 0;
  int         n_fail = 0;

  gpio_apb_if bus ();
  wire [7:0] pins;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign pins[i] = ext_oe[i] ? ext_val[i] : 1'bz;
  end

  gpio_apb dut (.PCLK(clk), .PRESETn(rst_n), .apb(bus.slave), .PINS(pins));

  always #5 clk = ~clk;

  // Pad value: driven by DUT where DIR=1, by the bench elsewhere.
  function automatic logic [7:0] m_pins();
    return (m_dir & m_port) | (~m_dir & ext_val);
  endfunction

  function automatic logic m_err(input logic [31:0] a, input logic w);
    return (a > 32'd3) || (w && a < 32'd2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_err(a, 1'b0)) return 32'd0;
    case (a)
      32'd0:   return {24'd0, m_pins()};
      32'd2:   return {24'd0, m_dir};
      32'd3:   return {24'd0, m_port};
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete transfer from IDLE; called just after a negedge.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                      output logic [31:0] rd, output logic rdy_s,
                      output logic rdy_a, output logic err_a);
    if (w && a == 32'd2) ext_oe = ~(m_dir | d[7:0]);
    bus.PSEL = 2'b01; bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = w;
    bus.PPROT = 3'($urandom);
    @(posedge clk); @(negedge clk);
    rdy_s = bus.PREADY;
    @(posedge clk); @(negedge clk);
    rdy_a = bus.PREADY; err_a = bus.PSLVERR; rd = bus.PRDATA;
    bus.PSEL = 2'b00;
    @(posedge clk);
    if (w && !m_err(a, w)) begin
      if (a == 32'd3) m_port = d[7:0];
      else            m_dir  = d[7:0];
    end
    @(negedge clk);
    ext_oe = ~m_dir;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ext_oe = '1; ext_val = 8'($urandom);
    m_dir = '0; m_port = '0;
    bus.PSEL = 2'b00; bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0; bus.PPROT = '0;
    idle(2);
    n_chk++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got PREADY=%b PSLVERR=%b PRDATA=%h, want 0 0 0",
               bus.PREADY, bus.PSLVERR, bus.PRDATA);
    end
    n_chk++;
    if (pins !== ext_val) begin
      n_fail++;
      $display("FAIL reset_pins_released: got %b, want %b", pins, ext_val);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_back_to_back();
    ext_oe = ~8'h0F; ext_val = 8'($urandom);
    bus.PSEL = 2'b01; bus.PADDR = 32'd2; bus.PWDATA = 32'd15; bus.PWRITE = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (bus.PREADY !== 1'(k % 2) || bus.PSLVERR !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got PREADY=%b PSLVERR=%b, want %b 0",
                 k, bus.PREADY, bus.PSLVERR, 1'(k % 2));
      end
    end
    bus.PSEL = 2'b00;
    m_dir = 8'h0F;
    idle(2);
    n_chk++;
    if (pins !== m_pins()) begin
      n_fail++;
      $display("FAIL b2b_pins: got %b, want %b", pins, m_pins());
    end
  endtask

  task automatic test_write_port();
    logic [31:0] rd; logic rs, ra, er;
    ext_val = 8'hA0;
    xfer(32'd3, 32'd7, 1'b1, rd, rs, ra, er);
    n_chk++;
    if (ra !== 1'b1 || er !== 1'b0 || rs !== 1'b0) begin
      n_fail++;
      $display("FAIL write_port_handshake: got setup_rdy=%b rdy=%b err=%b, want 0 1 0", rs, ra, er);
    end
    n_chk++;
    if (pins !== 8'hA7) begin
      n_fail++;
      $display("FAIL write_port_pins: got %b, want %b", pins, 8'hA7);
    end
  endtask

  task automatic test_read_dir();
    logic [31:0] rd; logic rs, ra, er;
    xfer(32'd2, 32'($urandom), 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== 32'h0000000F || ra !== 1'b1 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL read_dir: got rd=%h rdy=%b err=%b, want 0000000f 1 0", rd, ra, er);
    end
  endtask

  task automatic test_read_pin();
    logic [31:0] rd; logic rs, ra, er;
    idle(3);
    xfer(32'd0, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== 32'h000000A7) begin
      n_fail++;
      $display("FAIL read_pin: got %h, want 000000a7", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic rs, ra, er;
    logic [31:0] addrs [4] = '{32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      xfer(addrs[i], 32'($urandom), 1'b1, rd, rs, ra, er);
      n_chk++;
      if (er !== 1'b1 || ra !== 1'b1) begin
        n_fail++;
        $display("FAIL err_write_a%0h: got err=%b rdy=%b, want 1 1", addrs[i], er, ra);
      end
    end
    xfer(32'd2, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== {24'd0, m_dir}) begin
      n_fail++;
      $display("FAIL err_dir_unchanged: got %h, want %h", rd, {24'd0, m_dir});
    end
    xfer(32'd3, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== {24'd0, m_port}) begin
      n_fail++;
      $display("FAIL err_port_unchanged: got %h, want %h", rd, {24'd0, m_port});
    end
    xfer(32'd9, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_fail++;
      $display("FAIL err_read: got rd=%h err=%b, want 0 1", rd, er);
    end
    xfer(32'd1, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL read_reserved: got rd=%h err=%b, want 0 0", rd, er);
    end
    bus.PSEL = 2'b10; bus.PADDR = 32'd2; bus.PWRITE = 1'b1; bus.PWDATA = 32'hFF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      n_chk++;
      if (bus.PREADY !== 1'b0) begin
        n_fail++;
        $display("FAIL psel_other_cycle%0d: got PREADY=%b, want 0", k, bus.PREADY);
      end
    end
    bus.PSEL = 2'b00;
    xfer(32'd2, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== {24'd0, m_dir}) begin
      n_fail++;
      $display("FAIL psel_other_no_write: got %h, want %h", rd, {24'd0, m_dir});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic rs, ra, er;
    ext_oe = ~(m_dir | 8'h3C);
    bus.PSEL = 2'b01; bus.PADDR = 32'd2; bus.PWDATA = 32'h3C; bus.PWRITE = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_dir = '0; m_port = '0;
    n_chk++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got PREADY=%b PSLVERR=%b, want 0 0", bus.PREADY, bus.PSLVERR);
    end
    @(negedge clk);
    bus.PSEL = 2'b00; rst_n = 1'b1; ext_oe = '1;
    idle(1);
    xfer(32'd2, 32'd0, 1'b0, rd, rs, ra, er);
    n_chk++;
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_dir: got %h, want 0", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic rs, ra, er, w, exp_err;
    for (int n = 0; n < 40; n++) begin
      ext_val = 8'($urandom);
      idle(3);
      a = ($urandom % 8 == 0) ? 32'($urandom) : 32'($urandom % 6);
      d = 32'($urandom);
      w = 1'($urandom);
      exp_rd  = m_read(a);
      exp_err = m_err(a, w);
      xfer(a, d, w, rd, rs, ra, er);
      n_chk++;
      if (rs !== 1'b0 || ra !== 1'b1 || er !== exp_err || (!w && rd !== exp_rd)) begin
        n_fail++;
        $display("FAIL rand%0d a=%h w=%b: got rdy=%b%b err=%b rd=%h, want 01 %b %h",
                 n, a, w, rs, ra, er, rd, exp_err, exp_rd);
      end
      n_chk++;
      if (pins !== m_pins()) begin
        n_fail++;
        $display("FAIL rand%0d_pins: got %b, want %b", n, pins, m_pins());
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_write_port();
    test_read_dir();
    test_read_pin();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
